// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, register names and index helper for regfile_sb
package regfile_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_NUM_REGS   = 16;

   localparam int REG_R0  = 0;
   localparam int REG_LO  = 12;
   localparam int REG_HI  = 13;
   localparam int REG_R15 = 15;

   function automatic logic idx_in_range(input int unsigned idx, input int unsigned num_regs);
      return idx < num_regs;
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - write, read, reservation and flush signals of the register file
interface regfile_sb_if
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_REGS   = DEF_NUM_REGS,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS)
);
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [ADDR_WIDTH-1:0] rd_addr_a;
   logic [DATA_WIDTH-1:0] rd_data_a;
   logic                  rd_ready_a;
   logic [ADDR_WIDTH-1:0] rd_addr_b;
   logic [DATA_WIDTH-1:0] rd_data_b;
   logic                  rd_ready_b;
   logic                  ba_out;
   logic                  rsv_en;
   logic [ADDR_WIDTH-1:0] rsv_addr;
   logic                  rsv_grant;
   logic                  flush;
   logic [NUM_REGS-1:0]   busy_mask;

   modport master (
      output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, ba_out, rsv_en, rsv_addr, flush,
      input  rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, rsv_grant, busy_mask
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, ba_out, rsv_en, rsv_addr, flush,
      output rd_data_a, rd_ready_a, rd_data_b, rd_ready_b, rsv_grant, busy_mask
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits with reserve, writeback release and flush
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS   = DEF_NUM_REGS,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clock,
   input  logic                  clear_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic                  rsv_en,
   input  logic [ADDR_WIDTH-1:0] rsv_addr,
   input  logic                  flush,
   output logic                  rsv_grant,
   output logic [NUM_REGS-1:0]   busy_mask
);
   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic                wr_hit;
   logic                rsv_hit;

   always_comb begin
      wr_hit  = wr_en && idx_in_range(32'(wr_addr), NUM_REGS);
      rsv_hit = rsv_en && !flush && idx_in_range(32'(rsv_addr), NUM_REGS) && !busy_q[rsv_addr];
      busy_d  = busy_q;
      if (flush) begin
         busy_d = '0;
      end else begin
         if (wr_hit)
            busy_d[wr_addr] = 1'b0;
         // set after release so a same-edge reserve of the written register stays busy
         if (rsv_hit)
            busy_d[rsv_addr] = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   assign rsv_grant = rsv_hit;
   assign busy_mask = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - 1W2R register file with write bypass, R0 base-address gating and scoreboard
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int NUM_REGS   = DEF_NUM_REGS,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS),
   parameter bit BYPASS     = 1'b1,
   parameter bit R0_GATED   = 1'b1
) (
   input logic         clock,
   input logic         clear_n,
   regfile_sb_if.slave bus
);
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]   busy_mask;
   logic                  wr_valid;

   // clear_n term keeps a held write from leaking through the bypass while in reset
   assign wr_valid = bus.wr_en && clear_n && idx_in_range(32'(bus.wr_addr), NUM_REGS);

   regfile_scoreboard #(
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scoreboard (
      .clock     (clock),
      .clear_n   (clear_n),
      .wr_en     (bus.wr_en),
      .wr_addr   (bus.wr_addr),
      .rsv_en    (bus.rsv_en),
      .rsv_addr  (bus.rsv_addr),
      .flush     (bus.flush),
      .rsv_grant (bus.rsv_grant),
      .busy_mask (busy_mask)
   );

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs_q[i] <= '0;
      end else if (wr_valid) begin
         regs_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   function automatic logic [DATA_WIDTH-1:0] port_data(input logic [ADDR_WIDTH-1:0] a);
      logic [DATA_WIDTH-1:0] d;
      d = '0;
      if (idx_in_range(32'(a), NUM_REGS))
         d = regs_q[a];
      if (BYPASS && wr_valid && bus.wr_addr == a)
         d = bus.wr_data;
      return d;
   endfunction

   function automatic logic port_ready(input logic [ADDR_WIDTH-1:0] a);
      logic r;
      r = 1'b1;
      if (idx_in_range(32'(a), NUM_REGS))
         r = !busy_mask[a];
      if (BYPASS && wr_valid && bus.wr_addr == a)
         r = 1'b1;
      return r;
   endfunction

   assign bus.rd_data_a  = (R0_GATED && bus.ba_out && bus.rd_addr_a == ADDR_WIDTH'(REG_R0))
                         ? '0 : port_data(bus.rd_addr_a);
   assign bus.rd_data_b  = port_data(bus.rd_addr_b);
   assign bus.rd_ready_a = port_ready(bus.rd_addr_a);
   assign bus.rd_ready_b = port_ready(bus.rd_addr_b);
   assign bus.busy_mask  = busy_mask;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed and randomized checks of regfile_sb against a behavioural model
module tb_regfile_sb;
   import regfile_pkg::*;

   logic clk = 1'b0;
   logic clear_n;
   always #5 clk = ~clk;

   regfile_sb_if #(.DATA_WIDTH(32), .NUM_REGS(16), .ADDR_WIDTH(4)) bus ();
   regfile_sb_if #(.DATA_WIDTH(32), .NUM_REGS(12), .ADDR_WIDTH(4)) nbus ();

   regfile_sb #(.DATA_WIDTH(32), .NUM_REGS(16), .ADDR_WIDTH(4), .BYPASS(1'b1), .R0_GATED(1'b1))
      u_dut (.clock(clk), .clear_n(clear_n), .bus(bus));

   regfile_sb #(.DATA_WIDTH(32), .NUM_REGS(12), .ADDR_WIDTH(4), .BYPASS(1'b0), .R0_GATED(1'b0))
      u_nb (.clock(clk), .clear_n(clear_n), .bus(nbus));

   int checks   = 0;
   int failures = 0;

   logic [31:0] m_reg  [16];
   logic        m_busy [16];
   logic [31:0] o_rda, o_rdb;
   logic        o_rya, o_ryb, o_gnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_mask();
      logic [31:0] m;
      m = 0;
      for (int i = 0; i < 16; i++)
         if (m_busy[i]) m = m | (32'd1 << i);
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_reg[i]  = 0;
         m_busy[i] = 1'b0;
      end
   endtask

   // one clock of the main DUT; called at posedge+1, returns at the next posedge+1
   task automatic cyc(input logic we, input int wa, input logic [31:0] wd, input int ra, input int rb,
                      input logic ba, input logic re, input int rsa, input logic fl);
      logic [31:0] ea, eb;
      logic        ya, yb, g;
      bus.wr_en = we;  bus.wr_addr = 4'(wa);   bus.wr_data = wd;
      bus.rd_addr_a = 4'(ra); bus.rd_addr_b = 4'(rb); bus.ba_out = ba;
      bus.rsv_en = re; bus.rsv_addr = 4'(rsa); bus.flush = fl;
      ea = (we && wa == ra) ? wd : m_reg[ra];
      if (ba && ra == REG_R0) ea = 0;
      eb = (we && wa == rb) ? wd : m_reg[rb];
      ya = (we && wa == ra) ? 1'b1 : !m_busy[ra];
      yb = (we && wa == rb) ? 1'b1 : !m_busy[rb];
      g  = re && !fl && !m_busy[rsa];
      #1;
      o_rda = bus.rd_data_a; o_rdb = bus.rd_data_b;
      o_rya = bus.rd_ready_a; o_ryb = bus.rd_ready_b; o_gnt = bus.rsv_grant;
      check("rd_data_a", o_rda, ea);
      check("rd_data_b", o_rdb, eb);
      check("rd_ready_a", 32'(o_rya), 32'(ya));
      check("rd_ready_b", 32'(o_ryb), 32'(yb));
      check("rsv_grant", 32'(o_gnt), 32'(g));
      @(posedge clk);
      if (we) m_reg[wa] = wd;
      if (fl) begin
         for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
      end else begin
         if (we) m_busy[wa] = 1'b0;
         if (g)  m_busy[rsa] = 1'b1;
      end
      #1;
      check("busy_mask", 32'(bus.busy_mask), exp_mask());
   endtask

   task automatic idle_inputs();
      bus.wr_en = 0;  bus.wr_addr = 0;  bus.wr_data = 0;  bus.rd_addr_a = 0; bus.rd_addr_b = 0;
      bus.ba_out = 0; bus.rsv_en = 0;   bus.rsv_addr = 0; bus.flush = 0;
      nbus.wr_en = 0; nbus.wr_addr = 0; nbus.wr_data = 0; nbus.rd_addr_a = 0; nbus.rd_addr_b = 0;
      nbus.ba_out = 0; nbus.rsv_en = 0; nbus.rsv_addr = 0; nbus.flush = 0;
   endtask

   initial begin
      clear_n = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      bus.rd_addr_a = 4'd3;
      #1;
      check("reset_busy_mask", 32'(bus.busy_mask), 0);
      check("reset_rd_data_a", bus.rd_data_a, 0);
      check("reset_rd_ready_a", 32'(bus.rd_ready_a), 1);
      #2 clear_n = 1'b1;
      @(posedge clk); #1;

      // same-cycle bypass on port B
      cyc(1, 5, 32'h1234_5678, 0, 5, 0, 0, 0, 0);
      check("bypass_rd_b", o_rdb, 32'h1234_5678);

      // R0 gating only affects port A
      cyc(1, REG_R0, 32'h0000_00FF, 1, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, REG_R0, REG_R0, 1, 0, 0, 0);
      check("r0_gated_a", o_rda, 0);
      check("r0_port_b", o_rdb, 32'hFF);
      cyc(0, 1, 0, REG_R0, REG_R0, 0, 0, 0, 0);
      check("r0_ungated_a", o_rda, 32'hFF);

      // reservation round trip on R7
      cyc(0, 0, 0, 7, 0, 0, 1, 7, 0);
      check("r7_grant", 32'(o_gnt), 1);
      check("r7_busy", 32'(bus.busy_mask[7]), 1);
      cyc(0, 0, 0, 7, 0, 0, 1, 7, 0);
      check("r7_regrant", 32'(o_gnt), 0);
      check("r7_not_ready", 32'(o_rya), 0);
      cyc(1, 7, 32'h42, 7, 0, 0, 0, 0, 0);
      check("r7_wb_ready", 32'(o_rya), 1);
      check("r7_released", 32'(bus.busy_mask[7]), 0);

      // write/reserve collisions on R9
      cyc(0, 0, 0, 0, 0, 0, 1, 9, 0);
      cyc(1, 9, 32'hAAAA, 9, 0, 0, 1, 9, 0);
      check("r9_busy_collide_grant", 32'(o_gnt), 0);
      check("r9_busy_collide_mask", 32'(bus.busy_mask[9]), 0);
      cyc(1, 9, 32'hBBBB, 9, 0, 0, 1, 9, 0);
      check("r9_free_collide_grant", 32'(o_gnt), 1);
      check("r9_free_collide_mask", 32'(bus.busy_mask[9]), 1);
      cyc(0, 0, 0, 9, 0, 0, 0, 0, 0);
      check("r9_data", o_rda, 32'hBBBB);

      // flush
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 2, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 4, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 6, 0);
      check("busy_246", 32'(bus.busy_mask), 32'h0054);
      cyc(0, 0, 0, 2, 0, 0, 1, 1, 1);
      check("flush_grant", 32'(o_gnt), 0);
      check("flush_mask", 32'(bus.busy_mask), 0);
      cyc(0, 0, 0, 5, 9, 0, 0, 0, 0);
      check("flush_keeps_r5", o_rda, 32'h1234_5678);

      // HI/LO slots and top register
      cyc(1, REG_HI, 32'hC0FFEE01, 0, 0, 0, 0, 0, 0);
      cyc(1, REG_LO, 32'hC0FFEE02, 0, 0, 0, 0, 0, 0);
      cyc(1, REG_R15, 32'hF00D_F00D, REG_HI, REG_LO, 0, 0, 0, 0);
      cyc(0, 0, 0, REG_R15, REG_HI, 0, 0, 0, 0);

      // asynchronous reset mid-cycle, with a write held across the reset edge
      cyc(1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 3, 0, 0, 1, 8, 0);
      bus.wr_en = 1; bus.wr_addr = 4'd3; bus.wr_data = 32'h55; bus.rd_addr_a = 4'd3; bus.rsv_en = 0;
      #2 clear_n = 1'b0;
      #1;
      check("async_rd_data_a", bus.rd_data_a, 0);
      check("async_busy_mask", 32'(bus.busy_mask), 0);
      check("async_rd_ready_a", 32'(bus.rd_ready_a), 1);
      @(posedge clk);
      #3 clear_n = 1'b1;
      model_reset();
      idle_inputs();
      @(posedge clk); #1;
      cyc(0, 0, 0, 3, 8, 0, 0, 0, 0);

      // randomized traffic with a narrow address pool for collisions
      for (int n = 0; n < 400; n++) begin
         int wa, ra, rb, rsa;
         wa  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
         ra  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
         rb  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
         rsa = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
         cyc(1'($urandom_range(0, 1)), wa, $urandom, ra, rb, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), rsa, 1'($urandom_range(0, 15) == 0));
      end
      idle_inputs();

      // second instance: 12 registers, no bypass, no R0 gating
      @(posedge clk); #1;
      nbus.wr_en = 1; nbus.wr_addr = 4'd5; nbus.wr_data = 32'h11; nbus.rd_addr_b = 4'd5;
      #1 check("nb_old_before_edge", nbus.rd_data_b, 0);
      @(posedge clk); #1;
      check("nb_new_after_edge", nbus.rd_data_b, 32'h11);
      nbus.wr_addr = 4'd13; nbus.wr_data = 32'hABCD; nbus.rd_addr_a = 4'd13;
      #1;
      check("nb_oor_rd_data", nbus.rd_data_a, 0);
      check("nb_oor_rd_ready", 32'(nbus.rd_ready_a), 1);
      @(posedge clk); #1;
      check("nb_oor_wr_ignored", nbus.rd_data_b, 32'h11);
      check("nb_oor_rd_after", nbus.rd_data_a, 0);
      nbus.wr_en = 0; nbus.rsv_en = 1; nbus.rsv_addr = 4'd12;
      #1 check("nb_oor_grant", 32'(nbus.rsv_grant), 0);
      @(posedge clk); #1;
      check("nb_oor_mask", 32'(nbus.busy_mask), 0);
      nbus.rsv_en = 0; nbus.wr_en = 1; nbus.wr_addr = 4'd0; nbus.wr_data = 32'hFF;
      @(posedge clk); #1;
      nbus.wr_en = 0; nbus.ba_out = 1; nbus.rd_addr_a = 4'd0;
      #1 check("nb_r0_ungated", nbus.rd_data_a, 32'hFF);
      nbus.ba_out = 0; nbus.rsv_en = 1; nbus.rsv_addr = 4'd5;
      #1 check("nb_grant5", 32'(nbus.rsv_grant), 1);
      @(posedge clk); #1;
      check("nb_mask5", 32'(nbus.busy_mask), 32'h020);
      nbus.rsv_en = 0; nbus.wr_en = 1; nbus.wr_addr = 4'd5; nbus.wr_data = 32'h77; nbus.rd_addr_a = 4'd5;
      #1;
      check("nb_wb_not_ready", 32'(nbus.rd_ready_a), 0);
      check("nb_wb_old_data", nbus.rd_data_a, 32'h11);
      @(posedge clk); #1;
      nbus.wr_en = 0;
      #1;
      check("nb_wb_ready", 32'(nbus.rd_ready_a), 1);
      check("nb_wb_data", nbus.rd_data_a, 32'h77);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised general-purpose register file for the Mini SRC datapath. It replaces the individual per-register instances with one array that has one write port and two read ports. It also has a reservation scoreboard, so multi-cycle units (MUL/DIV) can mark a destination busy at issue and release it on writeback. Port A carries the R0/BAout zero-gating that the bus uses for base-address calculation.

Parameters:
DATA_WIDTH, 32, register width in bits
NUM_REGS, 16, number of registers (2..64; need not be a power of two)
ADDR_WIDTH, $clog2(NUM_REGS), register address width
BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads return stored value only
R0_GATED, 1, 1 = ba_out forces port A to zero when it reads R0

Ports:
clock  in  1  rising-edge clock
clear_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_WIDTH  write register index
wr_data  in  DATA_WIDTH  write data
rd_addr_a  in  ADDR_WIDTH  read port A index
rd_data_a  out  DATA_WIDTH  read port A data (combinational)
rd_ready_a  out  1  port A operand not pending
rd_addr_b  in  ADDR_WIDTH  read port B index
rd_data_b  out  DATA_WIDTH  read port B data (combinational)
rd_ready_b  out  1  port B operand not pending
ba_out  in  1  base-address mode for port A
rsv_en  in  1  reservation request
rsv_addr  in  ADDR_WIDTH  register to reserve
rsv_grant  out  1  reservation accepted this cycle (combinational)
flush  in  1  synchronous scoreboard clear
busy_mask  out  NUM_REGS  registered busy bits, bit i = register i

Behaviour:
- Reset: clock and reset are fixed as one clock (clock) and an asynchronous active-low reset (clear_n). While clear_n=0, all registers = 0 and busy_mask = 0, independent of clock. rd_data_* and rd_ready_* then follow combinationally: data 0, ready 1. Deassertion takes effect at the next rising edge.
- Write:
  - On a rising edge with wr_en=1 and wr_addr < NUM_REGS, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - Out-of-range wr_addr: no effect.
  - R0 is writable and stores data like any other register.
- Read (combinational, zero cycles):
  - rd_data_x = reg[rd_addr_x].
  - If BYPASS=1, wr_en=1 and wr_addr==rd_addr_x, then rd_data_x = wr_data.
  - Out-of-range rd_addr: data 0, ready 1.
- R0 gating: if R0_GATED=1, ba_out=1 and rd_addr_a==0, then rd_data_a = 0. This overrides bypass. Port B and rd_ready_a are unaffected.
- Ready: rd_ready_x = !busy[rd_addr_x]. If BYPASS=1, a same-cycle in-range write to that address also forces ready = 1.
- Reservation:
  - rsv_grant = rsv_en & !flush & (rsv_addr < NUM_REGS) & !busy[rsv_addr], using current (pre-edge) busy.
  - On an edge with rsv_grant=1, busy[rsv_addr] <= 1.
  - A request to an already-busy register is refused (grant 0) and causes no state change. The requester retries.
- Simultaneous events on the same edge:
  - Write and granted reservation to the same address: data is written and busy ends at 1 (reservation wins over release).
  - Write to a busy register while a reservation targets the same register: grant = 0 (busy is pre-edge), busy ends at 0.
  - Write and reservation to different addresses: both take effect.
- Flush: on an edge with flush=1, busy_mask <= 0 and no grant is issued. Register data is retained. A write on the same edge still updates data.
- Reset during operation: all pending reservations are lost, and a write in progress at the reset edge is discarded.
- Latency: write-to-read is 0 cycles with BYPASS=1 and 1 cycle with BYPASS=0. Reserve-to-busy is 1 edge.

Decomposition:
- Package regfile_pkg:
  - default DATA_WIDTH and NUM_REGS;
  - named register indices (R0, R15, HI/LO slots);
  - a function that checks an index is in range.
- One sub-module, regfile_scoreboard, owns:
  - the busy vector;
  - the grant, release and flush logic;
  - busy_mask.
- The top level holds the data array, the read muxing, bypass and R0 gating.

Test Plan:
- Reset: assert clear_n=0 mid-cycle after writing R3=0xDEADBEEF -> immediately rd_data_a(R3)=0, busy_mask=0, rd_ready_a=1.
- Bypass: wr_en=1, wr_addr=5, wr_data=0x12345678, rd_addr_b=5 in the same cycle -> rd_data_b=0x12345678 before the edge (BYPASS=1). With BYPASS=0 the old value shows until after the edge.
- R0 gating: R0=0x0000_00FF, ba_out=1, rd_addr_a=0, rd_addr_b=0 -> rd_data_a=0, rd_data_b=0xFF. With ba_out=0 -> rd_data_a=0xFF.
- Scoreboard round trip:
  - rsv_en on R7 -> rsv_grant=1, and after the edge busy_mask[7]=1, rd_ready_a(R7)=0.
  - A second rsv_en on R7 -> grant 0.
  - Write R7=0x42 -> ready during the write cycle (bypass), busy_mask[7]=0 after the edge.
- Collisions:
  - R9 busy, write R9 plus reserve R9 on the same edge -> grant 0, busy[9]=0.
  - R9 free, write R9 plus reserve R9 -> grant 1, R9 holds the new data, busy[9]=1.
- Flush: reserve R2, R4, R6 -> busy_mask=0x0054. Then flush=1 together with rsv_en on R1 -> grant 0, busy_mask=0 after the edge, register data unchanged.
